// File: rtl/store_align_unit.sv
// store_align_unit
// Places 1/2/4-byte right-justified stores onto an NB-lane memory bus.
// A store that crosses an NB boundary is either split into two beats
// or rejected, depending on ALLOW_MISALIGN.
//
// state | meaning
// IDLE  | waiting for a request; req_ready high
// BEAT0 | first (or only) bus beat presented, held until mem_ready
// BEAT1 | second beat of a boundary-crossing store
// FIN   | one-cycle done pulse (with err_misalign if rejected), then IDLE
module store_align_unit #(
  parameter int DATA_W         = 32,
  parameter int ALLOW_MISALIGN = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [1:0]          store_type,
  input  logic [31:0]         addr,
  input  logic [31:0]         wdata,
  output logic                mem_valid,
  input  logic                mem_ready,
  output logic [31:0]         mem_addr,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic                done,
  output logic                err_misalign,
  output logic                busy
);
  localparam int NB     = DATA_W / 8;
  localparam int OFFW   = $clog2(NB);
  localparam bit REJECT = (ALLOW_MISALIGN == 0);

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, FIN} state_t;

  state_t            state_q;
  logic [OFFW-1:0]   off_q;
  logic [2:0]        sz_q;
  logic [31:0]       wdata_q;
  logic [31:0]       base_q;
  logic              cross_q;

  logic              valid_q;
  logic [31:0]       maddr_q;
  logic [NB-1:0]     be_q;
  logic [DATA_W-1:0] wd_q;
  logic              done_q;
  logic              err_q;

  logic [OFFW-1:0]   off_in;
  logic [2:0]        sz_in;
  logic              cross_in;
  logic [31:0]       base_in;

  function automatic logic [2:0] size_of(input logic [1:0] t);
    case (t)
      2'b01:   return 3'd1;
      2'b10:   return 3'd2;
      2'b11:   return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

  // Lanes covered by the part of the store that lands in the first beat.
  function automatic logic [NB-1:0] be_lo(input logic [OFFW-1:0] o, input logic [2:0] s);
    logic [15:0] m;
    m = ((16'd1 << s) - 16'd1) << o;
    return m[NB-1:0];
  endfunction

  // Lanes covered by the spill-over into the next NB-aligned beat.
  function automatic logic [NB-1:0] be_hi(input logic [OFFW-1:0] o, input logic [2:0] s);
    logic [15:0] m;
    logic [4:0]  sh;
    sh = 5'(NB) - 5'(o);
    m  = ((16'd1 << s) - 16'd1) >> sh;
    return m[NB-1:0];
  endfunction

  function automatic logic [DATA_W-1:0] wd_lo(input logic [31:0] d, input logic [OFFW-1:0] o);
    logic [DATA_W+31:0] w;
    logic [6:0]         sh;
    sh = 7'(8 * int'(o));
    w  = {{DATA_W{1'b0}}, d} << sh;
    return w[DATA_W-1:0];
  endfunction

  function automatic logic [DATA_W-1:0] wd_hi(input logic [31:0] d, input logic [OFFW-1:0] o);
    logic [31:0] w;
    logic [6:0]  sh;
    sh = 7'(8 * (NB - int'(o)));
    w  = d >> sh;
    return DATA_W'(w);
  endfunction

  // Decode of the request as presented; only used on the acceptance edge.
  always_comb begin
    off_in   = addr[OFFW-1:0];
    sz_in    = size_of(store_type);
    cross_in = (5'(off_in) + 5'(sz_in)) > 5'(NB);
    base_in  = {addr[31:OFFW], {OFFW{1'b0}}};
  end

  // Sequencer: captures the request and builds each beat's payload one edge
  // ahead so the bus outputs come straight from registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      off_q   <= '0;
      sz_q    <= '0;
      wdata_q <= '0;
      base_q  <= '0;
      cross_q <= 1'b0;
      valid_q <= 1'b0;
      maddr_q <= '0;
      be_q    <= '0;
      wd_q    <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            off_q   <= off_in;
            sz_q    <= sz_in;
            wdata_q <= wdata;
            base_q  <= base_in;
            cross_q <= cross_in;
            if (sz_in == 3'd0) begin
              state_q <= FIN;
              done_q  <= 1'b1;
            end else if (cross_in && REJECT) begin
              state_q <= FIN;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end else begin
              state_q <= BEAT0;
              valid_q <= 1'b1;
              maddr_q <= base_in;
              be_q    <= be_lo(off_in, sz_in);
              wd_q    <= wd_lo(wdata, off_in);
            end
          end
        end
        BEAT0: begin
          if (mem_ready) begin
            if (cross_q) begin
              state_q <= BEAT1;
              maddr_q <= base_q + 32'(NB);
              be_q    <= be_hi(off_q, sz_q);
              wd_q    <= wd_hi(wdata_q, off_q);
            end else begin
              state_q <= FIN;
              valid_q <= 1'b0;
              be_q    <= '0;
              wd_q    <= '0;
              done_q  <= 1'b1;
            end
          end
        end
        BEAT1: begin
          if (mem_ready) begin
            state_q <= FIN;
            valid_q <= 1'b0;
            be_q    <= '0;
            wd_q    <= '0;
            done_q  <= 1'b1;
          end
        end
        FIN: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Reset masks every output immediately, including the cycle rst is first seen.
  assign req_ready    = (state_q == IDLE) && !rst;
  assign busy         = (state_q != IDLE) && !rst;
  assign mem_valid    = valid_q && !rst;
  assign mem_addr     = rst ? '0 : maddr_q;
  assign mem_be       = rst ? '0 : be_q;
  assign mem_wdata    = rst ? '0 : wd_q;
  assign done         = done_q && !rst;
  assign err_misalign = err_q && !rst;

endmodule

// File: tb/tb_store_align_unit.sv
// Bench for store_align_unit: a byte-placement model checks the default
// (32-bit, split) instance every cycle; directed literal checks cover it
// plus a rejecting 32-bit instance and a 64-bit instance.
module tb_store_align_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // instance a: DATA_W=32, ALLOW_MISALIGN=1
  logic        a_req_valid, a_req_ready, a_mem_valid, a_mem_ready;
  logic [1:0]  a_type;
  logic [31:0] a_addr, a_wdata, a_mem_addr, a_mem_wdata;
  logic [3:0]  a_mem_be;
  logic        a_done, a_err, a_busy;

  // instance r: DATA_W=32, ALLOW_MISALIGN=0
  logic        r_req_valid, r_req_ready, r_mem_valid, r_mem_ready;
  logic [1:0]  r_type;
  logic [31:0] r_addr, r_wdata, r_mem_addr, r_mem_wdata;
  logic [3:0]  r_mem_be;
  logic        r_done, r_err, r_busy;

  // instance w: DATA_W=64, ALLOW_MISALIGN=1
  logic        w_req_valid, w_req_ready, w_mem_valid, w_mem_ready;
  logic [1:0]  w_type;
  logic [31:0] w_addr, w_wdata, w_mem_addr;
  logic [63:0] w_mem_wdata;
  logic [7:0]  w_mem_be;
  logic        w_done, w_err, w_busy;

  store_align_unit #(.DATA_W(32), .ALLOW_MISALIGN(1)) u_a (
    .clk(clk), .rst(rst), .req_valid(a_req_valid), .req_ready(a_req_ready),
    .store_type(a_type), .addr(a_addr), .wdata(a_wdata),
    .mem_valid(a_mem_valid), .mem_ready(a_mem_ready), .mem_addr(a_mem_addr),
    .mem_be(a_mem_be), .mem_wdata(a_mem_wdata), .done(a_done),
    .err_misalign(a_err), .busy(a_busy));

  store_align_unit #(.DATA_W(32), .ALLOW_MISALIGN(0)) u_r (
    .clk(clk), .rst(rst), .req_valid(r_req_valid), .req_ready(r_req_ready),
    .store_type(r_type), .addr(r_addr), .wdata(r_wdata),
    .mem_valid(r_mem_valid), .mem_ready(r_mem_ready), .mem_addr(r_mem_addr),
    .mem_be(r_mem_be), .mem_wdata(r_mem_wdata), .done(r_done),
    .err_misalign(r_err), .busy(r_busy));

  store_align_unit #(.DATA_W(64), .ALLOW_MISALIGN(1)) u_w (
    .clk(clk), .rst(rst), .req_valid(w_req_valid), .req_ready(w_req_ready),
    .store_type(w_type), .addr(w_addr), .wdata(w_wdata),
    .mem_valid(w_mem_valid), .mem_ready(w_mem_ready), .mem_addr(w_mem_addr),
    .mem_be(w_mem_be), .mem_wdata(w_mem_wdata), .done(w_done),
    .err_misalign(w_err), .busy(w_busy));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- model of instance a ----------------
  typedef struct {
    logic [31:0] a;
    logic [3:0]  be;
    logic [31:0] d;
  } beat_t;

  beat_t exp_q[$];
  bit    exp_done = 1'b0;
  bit    nxt_done;
  bit    busy_exp;

  // Byte i of wdata lands at absolute position off+i from the aligned base;
  // only the first sz bytes are enabled.
  task automatic model_accept();
    int          sz, off, pos, k, lane;
    logic [31:0] base;
    beat_t       b [2];
    sz = (a_type == 2'b01) ? 1 : (a_type == 2'b10) ? 2 : (a_type == 2'b11) ? 4 : 0;
    if (sz == 0) begin
      nxt_done = 1'b1;
      return;
    end
    off  = int'(a_addr % 32'd4);
    base = a_addr - 32'(off);
    for (int j = 0; j < 2; j++) begin
      b[j].a  = base + 32'(4 * j);
      b[j].be = '0;
      b[j].d  = '0;
    end
    for (int i = 0; i < 4; i++) begin
      pos  = off + i;
      k    = pos / 4;
      lane = pos % 4;
      b[k].d[8*lane +: 8] = a_wdata[8*i +: 8];
      if (i < sz) b[k].be[lane] = 1'b1;
    end
    exp_q.push_back(b[0]);
    if (off + sz > 4) exp_q.push_back(b[1]);
  endtask

  // Per-cycle compare against the model, then advance it by what the next edge does.
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_req_ready", a_req_ready, 1'b0);
      chk("rst_mem_valid", a_mem_valid, 1'b0);
      chk("rst_mem_addr",  a_mem_addr,  32'h0);
      chk("rst_mem_be",    a_mem_be,    4'h0);
      chk("rst_mem_wdata", a_mem_wdata, 32'h0);
      chk("rst_done",      a_done,      1'b0);
      chk("rst_err",       a_err,       1'b0);
      chk("rst_busy",      a_busy,      1'b0);
      exp_q.delete();
      exp_done = 1'b0;
    end else begin
      busy_exp = (exp_q.size() != 0) || exp_done;
      chk("m_mem_valid", a_mem_valid, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
        chk("m_mem_addr",  a_mem_addr,  exp_q[0].a);
        chk("m_mem_be",    a_mem_be,    exp_q[0].be);
        chk("m_mem_wdata", a_mem_wdata, exp_q[0].d);
      end else begin
        chk("m_idle_be",    a_mem_be,    4'h0);
        chk("m_idle_wdata", a_mem_wdata, 32'h0);
      end
      chk("m_done",      a_done,      exp_done);
      chk("m_err",       a_err,       1'b0);
      chk("m_busy",      a_busy,      busy_exp);
      chk("m_req_ready", a_req_ready, !busy_exp);
      nxt_done = 1'b0;
      if (!busy_exp && a_req_valid) begin
        model_accept();
      end else if (exp_q.size() != 0 && a_mem_ready) begin
        void'(exp_q.pop_front());
        if (exp_q.size() == 0) nxt_done = 1'b1;
      end
      exp_done = nxt_done;
    end
  end

  int hs104 = 0;
  always @(negedge clk)
    if (!rst && a_mem_valid && a_mem_ready && a_mem_addr == 32'h104) hs104++;

  // ---------------- stimulus helpers for instance a ----------------
  task automatic a_issue(input logic [1:0] t, input logic [31:0] ad, input logic [31:0] d);
    int k = 0;
    a_req_valid = 1'b1;
    a_type      = t;
    a_addr      = ad;
    a_wdata     = d;
    @(negedge clk);
    while (!a_req_ready && k < 20) begin
      tick();
      @(negedge clk);
      k++;
    end
    chk("issue_ready", a_req_ready, 1'b1);
    tick();
    a_req_valid = 1'b0;
    a_type      = 2'b01;
    a_addr      = 32'hFFFF_FFFF;
    a_wdata     = 32'h0BAD_F00D;
  endtask

  task automatic a_cyc(input string n, input logic v, input logic [31:0] ad,
                       input logic [3:0] be, input logic [31:0] d, input logic dn);
    @(negedge clk);
    chk({n, "_valid"}, a_mem_valid, v);
    if (v) chk({n, "_addr"}, a_mem_addr, ad);
    chk({n, "_be"},    a_mem_be,    be);
    chk({n, "_wdata"}, a_mem_wdata, d);
    chk({n, "_done"},  a_done,      dn);
    tick();
  endtask

  task automatic a_finish(input string name);
    int k = 0;
    @(negedge clk);
    while (!a_done && k < 20) begin
      @(posedge clk);
      #1;
      a_mem_ready = 1'b1;
      @(negedge clk);
      k++;
    end
    chk({name, "_done_seen"}, a_done, 1'b1);
    tick();
  endtask

  typedef struct {
    logic [1:0]  t;
    logic [31:0] a;
    logic [31:0] d;
  } vec_t;

  vec_t vecs [6] = '{
    '{2'b11, 32'h0000_0101, 32'h0102_0304},
    '{2'b10, 32'h0000_0102, 32'h0000_ABCD},
    '{2'b01, 32'h0000_0101, 32'hDEAD_BEEF},
    '{2'b11, 32'h0000_01FF, 32'h5566_7788},
    '{2'b10, 32'hFFFF_FFFF, 32'h0000_9876},
    '{2'b00, 32'h0000_0123, 32'h1111_1111}
  };

  int h0;

  initial begin
    a_req_valid = 0; a_type = 0; a_addr = 0; a_wdata = 0; a_mem_ready = 1;
    r_req_valid = 0; r_type = 0; r_addr = 0; r_wdata = 0; r_mem_ready = 1;
    w_req_valid = 0; w_type = 0; w_addr = 0; w_wdata = 0; w_mem_ready = 1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("reset_ready_a", a_req_ready, 1'b0);
    chk("reset_busy_w",  w_busy,      1'b0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("idle_ready_a", a_req_ready, 1'b1);
    tick();

    // aligned word: one beat, done the cycle after the handshake
    a_issue(2'b11, 32'h100, 32'hAABB_CCDD);
    a_cyc("word_b0",   1'b1, 32'h100, 4'hF, 32'hAABB_CCDD, 1'b0);
    a_cyc("word_fin",  1'b0, 32'h0,   4'h0, 32'h0,         1'b1);
    a_cyc("word_idle", 1'b0, 32'h0,   4'h0, 32'h0,         1'b0);

    // byte in the top lane
    a_issue(2'b01, 32'h103, 32'h0000_00EF);
    a_cyc("byte_b0",  1'b1, 32'h100, 4'h8, 32'hEF00_0000, 1'b0);
    a_cyc("byte_fin", 1'b0, 32'h0,   4'h0, 32'h0,         1'b1);

    // halfword in middle lanes, with one BEAT0 stall cycle
    a_issue(2'b10, 32'h101, 32'h0000_1234);
    a_mem_ready = 1'b0;
    a_cyc("half_hold", 1'b1, 32'h100, 4'h6, 32'h0012_3400, 1'b0);
    a_mem_ready = 1'b1;
    a_cyc("half_b0",   1'b1, 32'h100, 4'h6, 32'h0012_3400, 1'b0);
    a_cyc("half_fin",  1'b0, 32'h0,   4'h0, 32'h0,         1'b1);

    // crossing halfword split into two beats
    a_issue(2'b10, 32'h103, 32'h0000_1234);
    a_cyc("xh_b0",  1'b1, 32'h100, 4'h8, 32'h3400_0000, 1'b0);
    a_cyc("xh_b1",  1'b1, 32'h104, 4'h1, 32'h0000_0012, 1'b0);
    a_cyc("xh_fin", 1'b0, 32'h0,   4'h0, 32'h0,         1'b1);

    // crossing word with a 3-cycle stall in BEAT1
    h0 = hs104;
    a_issue(2'b11, 32'h102, 32'hCAFE_BABE);
    a_cyc("st_b0", 1'b1, 32'h100, 4'hC, 32'hBABE_0000, 1'b0);
    a_mem_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      a_cyc("st_b1_hold", 1'b1, 32'h104, 4'h3, 32'h0000_CAFE, 1'b0);
    a_mem_ready = 1'b1;
    a_cyc("st_b1",  1'b1, 32'h104, 4'h3, 32'h0000_CAFE, 1'b0);
    a_cyc("st_fin", 1'b0, 32'h0,   4'h0, 32'h0,         1'b1);
    chk("st_b1_handshakes", 64'(hs104 - h0), 64'd1);

    // store_type none: done without any bus beat
    a_issue(2'b00, 32'h100, 32'h1234_5678);
    a_cyc("none_fin",  1'b0, 32'h0, 4'h0, 32'h0, 1'b1);
    a_cyc("none_idle", 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);

    // reset during BEAT1: store abandoned, no done
    a_issue(2'b11, 32'h103, 32'h1122_3344);
    a_cyc("rb_b0", 1'b1, 32'h100, 4'h8, 32'h4400_0000, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("rb_rst_valid", a_mem_valid, 1'b0);
    chk("rb_rst_busy",  a_busy,      1'b0);
    tick();
    rst = 1'b0;
    a_cyc("rb_after",  1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
    a_cyc("rb_after2", 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);

    // table of further patterns, alternating an initial stall
    for (int i = 0; i < 6; i++) begin
      a_issue(vecs[i].t, vecs[i].a, vecs[i].d);
      a_mem_ready = (i % 2 == 0);
      a_finish("vec");
    end

    // request held high: repeated acceptances separated by IDLE
    a_req_valid = 1'b1; a_type = 2'b01; a_addr = 32'h102; a_wdata = 32'h0000_005A;
    repeat (12) tick();
    a_req_valid = 1'b0;
    repeat (5) tick();

    // rejecting instance
    r_req_valid = 1'b1; r_type = 2'b10; r_addr = 32'h103; r_wdata = 32'h0000_1234;
    @(negedge clk);
    chk("rej_ready", r_req_ready, 1'b1);
    tick();
    r_req_valid = 1'b0; r_addr = 32'h0;
    @(negedge clk);
    chk("rej_valid", r_mem_valid, 1'b0);
    chk("rej_done",  r_done,      1'b1);
    chk("rej_err",   r_err,       1'b1);
    tick();
    @(negedge clk);
    chk("rej_done_clr", r_done,      1'b0);
    chk("rej_err_clr",  r_err,       1'b0);
    chk("rej_valid2",   r_mem_valid, 1'b0);
    chk("rej_idle",     r_req_ready, 1'b1);
    tick();
    r_req_valid = 1'b1; r_type = 2'b11; r_addr = 32'h200; r_wdata = 32'h0123_4567;
    tick();
    r_req_valid = 1'b0;
    @(negedge clk);
    chk("rej_al_valid", r_mem_valid, 1'b1);
    chk("rej_al_addr",  r_mem_addr,  32'h200);
    chk("rej_al_be",    r_mem_be,    4'hF);
    chk("rej_al_wdata", r_mem_wdata, 32'h0123_4567);
    tick();
    @(negedge clk);
    chk("rej_al_done", r_done, 1'b1);
    chk("rej_al_err",  r_err,  1'b0);
    tick();

    // 64-bit instance: crossing word at offset 6
    w_req_valid = 1'b1; w_type = 2'b11; w_addr = 32'h106; w_wdata = 32'h1122_3344;
    @(negedge clk);
    chk("w_ready", w_req_ready, 1'b1);
    tick();
    w_req_valid = 1'b0; w_wdata = 32'h0;
    @(negedge clk);
    chk("w_b0_addr",  w_mem_addr,  32'h100);
    chk("w_b0_be",    w_mem_be,    8'hC0);
    chk("w_b0_wdata", w_mem_wdata, 64'h3344_0000_0000_0000);
    tick();
    @(negedge clk);
    chk("w_b1_addr",  w_mem_addr,  32'h108);
    chk("w_b1_be",    w_mem_be,    8'h03);
    chk("w_b1_wdata", w_mem_wdata, 64'h0000_0000_0000_1122);
    tick();
    @(negedge clk);
    chk("w_fin_done", w_done, 1'b1);
    tick();
    // word at offset 4 fits one beat
    w_req_valid = 1'b1; w_type = 2'b11; w_addr = 32'h104; w_wdata = 32'h1122_3344;
    tick();
    w_req_valid = 1'b0;
    @(negedge clk);
    chk("w4_addr",  w_mem_addr,  32'h100);
    chk("w4_be",    w_mem_be,    8'hF0);
    chk("w4_wdata", w_mem_wdata, 64'h1122_3344_0000_0000);
    tick();
    @(negedge clk);
    chk("w4_done",  w_done,      1'b1);
    chk("w4_valid", w_mem_valid, 1'b0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
